// File: rtl/clk_reset_seq.sv
// clk_reset_seq: card-wide synchronous reset sequencer and CPU/bus clock-enable generator.
// Optional macro CLK_RESET_SEQ_LOCK_WAIT_EN: also hold reset until the synchronized PLL lock is high.
module clk_reset_seq #(
  parameter int HOLD_CYCLES = 1024,
  parameter int CE_DIV      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic bus_reset_n_i,
  input  logic pll_lock_i,
  output logic sys_reset_o,
  output logic ce_o,
  output logic ce_phase_o,
  output logic running_o
);

  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int CW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam logic [DW-1:0] DCNT_MAX = DW'(DEBOUNCE - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] DIV_MAX  = CW'(CE_DIV - 1);

  typedef enum logic [0:0] {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] bsync_q, bsync_d;
  logic [DW-1:0]          dcnt_q, dcnt_d;
  logic                   bus_rst_act_q, bus_rst_act_d;
  logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
  logic [CW-1:0]          div_q, div_d;
  logic                   sys_reset_q, sys_reset_d;
  logic                   ce_q, ce_d;
  logic                   ce_phase_q, ce_phase_d;
  logic                   running_q, running_d;
  logic                   rst_src_s;

`ifdef CLK_RESET_SEQ_LOCK_WAIT_EN
  logic [SYNC_STAGES-1:0] lsync_q;

  // PLL lock synchronizer; an unlocked PLL counts as an active reset source.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lsync_q <= {SYNC_STAGES{1'b0}};
    end else begin
      lsync_q <= {lsync_q[SYNC_STAGES-2:0], pll_lock_i};
    end
  end

  assign rst_src_s = bus_rst_act_q | ~lsync_q[SYNC_STAGES-1];
`else
  logic pll_lock_unused_s;
  assign pll_lock_unused_s = pll_lock_i;
  assign rst_src_s         = bus_rst_act_q;
`endif

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= HOLD;
      bsync_q       <= {SYNC_STAGES{1'b0}};
      dcnt_q        <= {DW{1'b0}};
      bus_rst_act_q <= 1'b1;
      hold_cnt_q    <= {HW{1'b0}};
      div_q         <= {CW{1'b0}};
      sys_reset_q   <= 1'b1;
      ce_q          <= 1'b0;
      ce_phase_q    <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      bsync_q       <= bsync_d;
      dcnt_q        <= dcnt_d;
      bus_rst_act_q <= bus_rst_act_d;
      hold_cnt_q    <= hold_cnt_d;
      div_q         <= div_d;
      sys_reset_q   <= sys_reset_d;
      ce_q          <= ce_d;
      ce_phase_q    <= ce_phase_d;
      running_q     <= running_d;
    end
  end

  // Debounce and sequencing next-state logic.
  always_comb begin
    bsync_d       = {bsync_q[SYNC_STAGES-2:0], bus_reset_n_i};
    state_d       = state_q;
    dcnt_d        = dcnt_q;
    bus_rst_act_d = bus_rst_act_q;
    hold_cnt_d    = hold_cnt_q;
    div_d         = div_q;
    sys_reset_d   = sys_reset_q;
    ce_d          = 1'b0;
    ce_phase_d    = ce_phase_q;
    running_d     = running_q;

    // Bus reset asserts immediately; release needs DEBOUNCE clean samples in a row.
    if (!bsync_q[SYNC_STAGES-1]) begin
      dcnt_d        = {DW{1'b0}};
      bus_rst_act_d = 1'b1;
    end else if (dcnt_q == DCNT_MAX) begin
      bus_rst_act_d = 1'b0;
    end else begin
      dcnt_d = dcnt_q + DW'(1);
    end

    case (state_q)
      HOLD: begin
        sys_reset_d = 1'b1;
        running_d   = 1'b0;
        div_d       = {CW{1'b0}};
        if (rst_src_s) begin
          hold_cnt_d = {HW{1'b0}};
        end else if (hold_cnt_q == HOLD_MAX) begin
          state_d     = RUN;
          sys_reset_d = 1'b0;
          running_d   = 1'b1;
          hold_cnt_d  = {HW{1'b0}};
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      RUN: begin
        if (rst_src_s) begin
          state_d     = HOLD;
          sys_reset_d = 1'b1;
          running_d   = 1'b0;
          hold_cnt_d  = {HW{1'b0}};
          div_d       = {CW{1'b0}};
        end else if (div_q == DIV_MAX) begin
          div_d      = {CW{1'b0}};
          ce_d       = 1'b1;
          ce_phase_d = ~ce_phase_q;
        end else begin
          div_d = div_q + CW'(1);
        end
      end
      default: begin
        state_d     = HOLD;
        sys_reset_d = 1'b1;
        running_d   = 1'b0;
        hold_cnt_d  = {HW{1'b0}};
        div_d       = {CW{1'b0}};
      end
    endcase
  end

  assign sys_reset_o = sys_reset_q;
  assign ce_o        = ce_q;
  assign ce_phase_o  = ce_phase_q;
  assign running_o   = running_q;

endmodule

// File: tb/tb_clk_reset_seq.sv
// Directed bench for clk_reset_seq: CE_DIV=4 and CE_DIV=1 instances share all inputs.
module tb_clk_reset_seq;

  localparam int BIG = 100000;

  logic clk;
  logic reset;
  logic bus_reset_n;
  logic pll_lock;
  logic sr4, ce4, ph4, run4;
  logic sr1, ce1, ph1, run1;

  int checks;
  int errors;
  int e;
  int win_s [3];
  int win_e [3];
  int nwin;
  logic exp_ph4;
  logic exp_ph1;

  clk_reset_seq #(
    .HOLD_CYCLES(8), .CE_DIV(4), .SYNC_STAGES(2), .DEBOUNCE(4)
  ) u_dut4 (
    .clk_i(clk), .reset_i(reset), .bus_reset_n_i(bus_reset_n), .pll_lock_i(pll_lock),
    .sys_reset_o(sr4), .ce_o(ce4), .ce_phase_o(ph4), .running_o(run4)
  );

  clk_reset_seq #(
    .HOLD_CYCLES(8), .CE_DIV(1), .SYNC_STAGES(2), .DEBOUNCE(4)
  ) u_dut1 (
    .clk_i(clk), .reset_i(reset), .bus_reset_n_i(bus_reset_n), .pll_lock_i(pll_lock),
    .sys_reset_o(sr1), .ce_o(ce1), .ce_phase_o(ph1), .running_o(run1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  // One edge with reset asserted: everything must be in its reset state.
  task automatic reset_edge(input string tag);
    @(posedge clk);
    #1;
    chk({tag, " sys_reset4"}, sr4, 1'b1);
    chk({tag, " ce4"}, ce4, 1'b0);
    chk({tag, " ce_phase4"}, ph4, 1'b0);
    chk({tag, " running4"}, run4, 1'b0);
    chk({tag, " sys_reset1"}, sr1, 1'b1);
    chk({tag, " ce1"}, ce1, 1'b0);
    chk({tag, " ce_phase1"}, ph1, 1'b0);
    exp_ph4 = 1'b0;
    exp_ph1 = 1'b0;
  endtask

  // Advance one edge and check against the RUN-window table.
  task automatic step_check();
    logic in_run;
    int   r;
    logic x_ce4, x_ce1;
    @(posedge clk);
    #1;
    e++;
    in_run = 1'b0;
    r = 0;
    for (int i = 0; i < nwin; i++) begin
      if (e >= win_s[i] && e < win_e[i]) begin
        in_run = 1'b1;
        r = win_s[i];
      end
    end
    x_ce4 = in_run && (e > r) && ((e - r) % 4 == 0);
    x_ce1 = in_run && (e > r);
    exp_ph4 = exp_ph4 ^ x_ce4;
    exp_ph1 = exp_ph1 ^ x_ce1;
    chk($sformatf("sys_reset4@%0d", e), sr4, ~in_run);
    chk($sformatf("running4@%0d", e), run4, in_run);
    chk($sformatf("ce4@%0d", e), ce4, x_ce4);
    chk($sformatf("ce_phase4@%0d", e), ph4, exp_ph4);
    chk($sformatf("sys_reset1@%0d", e), sr1, ~in_run);
    chk($sformatf("running1@%0d", e), run1, in_run);
    chk($sformatf("ce1@%0d", e), ce1, x_ce1);
    chk($sformatf("ce_phase1@%0d", e), ph1, exp_ph1);
  endtask

  task automatic run_to(input int last);
    while (e < last) step_check();
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    e           = 0;
    reset       = 1'b1;
    bus_reset_n = 1'b1;
    pll_lock    = 1'b1;
    exp_ph4     = 1'b0;
    exp_ph1     = 1'b0;

    reset_edge("init0");
    reset_edge("init1");
    reset = 1'b0;

    // Power-up, 1-cycle bus reset at 30, bounced bus reset from 56.
    e = 0;
    nwin = 3;
    win_s[0] = 14; win_e[0] = 34;
    win_s[1] = 45; win_e[1] = 60;
    win_s[2] = 76; win_e[2] = BIG;
    run_to(30);
    bus_reset_n = 1'b0;
    run_to(31);
    bus_reset_n = 1'b1;
    run_to(56);
    bus_reset_n = 1'b0;
    run_to(58);
    bus_reset_n = 1'b1;
    run_to(61);
    bus_reset_n = 1'b0;
    run_to(62);
    bus_reset_n = 1'b1;
    run_to(90);

    // Synchronous reset pulse in the middle of RUN, then power-up again.
    reset = 1'b1;
    reset_edge("midrun");
    reset = 1'b0;
    e = 0;
    nwin = 1;
    win_s[0] = 14; win_e[0] = BIG;
    run_to(30);

`ifdef CLK_RESET_SEQ_LOCK_WAIT_EN
    // PLL unlocked for 50 cycles, then a lock drop while running.
    reset    = 1'b1;
    pll_lock = 1'b0;
    reset_edge("lock");
    reset = 1'b0;
    e = 0;
    nwin = 1;
    win_s[0] = 60; win_e[0] = 73;
    run_to(50);
    pll_lock = 1'b1;
    run_to(70);
    pll_lock = 1'b0;
    run_to(80);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
